// File: rtl/cache_fill_fsm_pkg.sv
// rtl/cache_fill_fsm_pkg.sv - shared sizes and state encoding for the cache fill controller
package cache_fill_fsm_pkg;

  localparam int FILL_ADDR_W          = 16;
  localparam int FILL_DATA_W          = 16;
  localparam int FILL_WORDS_PER_BLOCK = 8;
  localparam int BLOCK_BYTES          = 2 * FILL_WORDS_PER_BLOCK;

  typedef enum logic [1:0] {
    FILL_IDLE = 2'd0,
    FILL_BUSY = 2'd1,
    FILL_DONE = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_fill_fsm_dff.sv
// rtl/cache_fill_fsm_dff.sv - single-bit flop with synchronous active-high clear
module cache_fill_fsm_dff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) q <= 1'b0;
    else     q <= d;
  end

endmodule

// File: rtl/cache_fill_fsm.sv
// rtl/cache_fill_fsm.sv - miss fill controller: fetches one block, writes data words and tag
module cache_fill_fsm
  import cache_fill_fsm_pkg::*;
#(
  parameter  int ADDR_W          = FILL_ADDR_W,
  parameter  int DATA_W          = FILL_DATA_W,
  parameter  int WORDS_PER_BLOCK = FILL_WORDS_PER_BLOCK,
  localparam int WIDX_W          = $clog2(WORDS_PER_BLOCK)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_detected,
  input  logic [ADDR_W-1:0] miss_address,
  input  logic              mem_grant,
  input  logic              mem_data_valid,
  input  logic [DATA_W-1:0] mem_data,
  output logic              fsm_busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              data_we,
  output logic [WIDX_W-1:0] data_word_idx,
  output logic [DATA_W-1:0] data_wdata,
  output logic              tag_we,
  output logic              fill_done
);

  localparam int                CNT_W    = WIDX_W + 1;
  localparam int                REG_W    = 2 + 2 * CNT_W + ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'(2 * WORDS_PER_BLOCK - 1);

  fill_state_t       state_q, state_d;
  logic [CNT_W-1:0]  issue_q, issue_d;
  logic [CNT_W-1:0]  rx_q, rx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [REG_W-1:0]  reg_d, reg_q;
  logic              in_fill;

  // All controller state lives in one vector of bit-cells, all clearing to zero (FILL_IDLE).
  assign reg_d = {base_d, rx_d, issue_d, state_d};

  for (genvar i = 0; i < REG_W; i++) begin : g_state_bit
    cache_fill_fsm_dff u_dff (
      .clk (clk),
      .rst (rst),
      .d   (reg_d[i]),
      .q   (reg_q[i])
    );
  end

  assign state_q = fill_state_t'(reg_q[1:0]);
  assign issue_q = reg_q[2 +: CNT_W];
  assign rx_q    = reg_q[2 + CNT_W +: CNT_W];
  assign base_q  = reg_q[2 + 2 * CNT_W +: ADDR_W];

  assign in_fill       = (state_q == FILL_BUSY);
  assign fsm_busy      = (state_q == FILL_BUSY) || (state_q == FILL_DONE);
  assign fill_done     = (state_q == FILL_DONE);
  assign mem_req       = in_fill && (issue_q < CNT_FULL);
  assign mem_addr      = mem_req ? base_q + {{(ADDR_W - CNT_W - 1){1'b0}}, issue_q, 1'b0} : '0;
  // Returns beyond the block length are dropped so rx_q can never pass CNT_FULL.
  assign data_we       = in_fill && mem_data_valid && (rx_q < CNT_FULL);
  assign tag_we        = data_we && (rx_q == CNT_LAST);
  assign data_word_idx = data_we ? rx_q[WIDX_W-1:0] : '0;
  assign data_wdata    = mem_data;

  always_comb begin
    state_d = state_q;
    issue_d = issue_q;
    rx_d    = rx_q;
    base_d  = base_q;
    case (state_q)
      FILL_IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address & ~OFS_MASK;
          issue_d = '0;
          rx_d    = '0;
          state_d = FILL_BUSY;
        end
      end
      FILL_BUSY: begin
        if (mem_req && mem_grant) issue_d = issue_q + CNT_W'(1);
        if (data_we)              rx_d    = rx_q + CNT_W'(1);
        if (tag_we)               state_d = FILL_DONE;
      end
      FILL_DONE: state_d = FILL_IDLE;
      default:   state_d = FILL_IDLE;
    endcase
  end

endmodule
